// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor computing a - b - bin (mod 2^WIDTH),
//               one bit per clock, LSB first. Three-state FSM
//               (IDLE / SHIFT / DONE) with registered busy/done/result.
//               Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow
//               output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter just wide enough to hold the value WIDTH.
  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_a0;
  logic               w_b0;
  logic               w_d;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_res_next;

  // Full-subtractor slice on the current operand LSBs and the borrow register.
  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_br;
  assign w_borrow   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // DONE accepts start too, so operations can run back to back.
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
            busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          // start is deliberately ignored here.
          r_res <= w_res_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_borrow;
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            // Last bit: publish the full result in one shot so diff never
            // shows a partial value.
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_res_next;
            bout    <= w_borrow;
`ifdef SERIAL_SUB_OVF_EN
            // r_br is the borrow into the MSB, w_borrow the borrow out of it.
            ovf     <= r_br ^ w_borrow;
`endif
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH=8).
//               Checks ovf when SERIAL_SUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  // Returns at the negedge after acceptance (first busy cycle).
  task automatic launch(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_nodone"}, 32'(done), 32'd0);
  endtask

  // Wait (bounded) for done; verify latency, result hold and result.
  task automatic wait_done(input string tag, input logic [WIDTH-1:0] ediff,
                           input logic ebout, input logic eovf);
    int             cyc;
    logic [WIDTH-1:0] held;
    logic           hold_ok;
    held    = diff;
    hold_ok = 1'b1;
    cyc     = 0;
    while (!done && cyc < WIDTH + 4) begin
      @(negedge clk);
      cyc++;
      if (!done && diff !== held) hold_ok = 1'b0;
      if (done && busy) hold_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ediff));
    check({tag, "_bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected X ovf argument");
`endif
  endtask

  // Let DONE expire and confirm outputs hold.
  task automatic settle(input string tag, input logic [WIDTH-1:0] ediff);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
    check({tag, "_diff_held"}, 32'(diff), 32'(ediff));
  endtask

  initial begin
    int npulse;
    logic [WIDTH-1:0] seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // S1..S4 plus extra corners
    launch("s1", 8'h05, 8'h03, 1'b0); wait_done("s1", 8'h02, 1'b0, 1'b0); settle("s1", 8'h02);
    launch("s2", 8'h03, 8'h05, 1'b0); wait_done("s2", 8'hFE, 1'b1, 1'b0); settle("s2", 8'hFE);
    launch("s3", 8'h00, 8'h00, 1'b1); wait_done("s3", 8'hFF, 1'b1, 1'b0); settle("s3", 8'hFF);
    launch("s4", 8'h80, 8'h01, 1'b0); wait_done("s4", 8'h7F, 1'b0, 1'b1); settle("s4", 8'h7F);
    launch("x1", 8'h7F, 8'hFF, 1'b0); wait_done("x1", 8'h80, 1'b1, 1'b1); settle("x1", 8'h80);

    // Back-to-back: start issued in the DONE cycle
    launch("b2b_a", 8'hFF, 8'hFF, 1'b1); wait_done("b2b_a", 8'hFF, 1'b1, 1'b0);
    launch("b2b_b", 8'hA5, 8'h5A, 1'b0); wait_done("b2b_b", 8'h4B, 1'b0, 1'b1); settle("b2b_b", 8'h4B);

    // S5: start during busy is ignored; exactly one done pulse
    launch("s5", 8'h10, 8'h01, 1'b0);
    @(negedge clk); @(negedge clk);   // third busy cycle
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0; seen = '0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (done) begin npulse++; seen = diff; end
      @(negedge clk);
    end
    check("s5_pulses", 32'(npulse), 32'd1);
    check("s5_diff", 32'(seen), 32'h0F);

    // S6: asynchronous reset mid-operation
    launch("s6", 8'h55, 8'h11, 1'b0);
    repeat (3) @(negedge clk);         // fourth busy cycle
    #2 rst_n = 1'b0;
    #1;
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_done", 32'(done), 32'd0);
    check("s6_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (done || busy) npulse++;
    end
    check("s6_quiet", 32'(npulse), 32'd0);
    launch("s6_s1", 8'h05, 8'h03, 1'b0); wait_done("s6_s1", 8'h02, 1'b0, 1'b0); settle("s6_s1", 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
